// File: rtl/wishbone_timer.sv
// rtl/wishbone_timer.sv - Wishbone classic timer: prescaled 32-bit counter, compare, match flag, irq
module wishbone_timer #(
   parameter int PRESCALE_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        irq_o
);

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_COMPARE  = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;

   logic [2:0]            ctrl;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic [31:0]           count;
   logic [31:0]           compare;
   logic                  match;
   logic                  tick;

   logic        accept;
   logic        wr_en;
   logic [2:0]  idx;
   logic [31:0] rdata;
   logic [31:0] ctrl_wr;
   logic [31:0] pre_wr;
   logic [31:0] count_wr;
   logic [31:0] compare_wr;
   logic [31:0] count_tick;
   logic        match_set;
   logic        pre_hit;
   logic        unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   assign accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr_en   = accept & wb_we_i;
   assign idx     = wb_adr_i[4:2];
   assign pre_hit = (pre_cnt == prescale);
   assign irq_o   = match & ctrl[2];

   assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], ctrl_wr[31:3], pre_wr[31:PRESCALE_W]};

   always_comb begin
      ctrl_wr    = merge_bytes(32'(ctrl), wb_dat_i, wb_sel_i);
      pre_wr     = merge_bytes(32'(prescale), wb_dat_i, wb_sel_i);
      count_wr   = merge_bytes(count, wb_dat_i, wb_sel_i);
      compare_wr = merge_bytes(compare, wb_dat_i, wb_sel_i);
   end

   always_comb begin
      case (idx)
         REG_CTRL:     rdata = 32'(ctrl);
         REG_PRESCALE: rdata = 32'(prescale);
         REG_COUNT:    rdata = count;
         REG_COMPARE:  rdata = compare;
         REG_STATUS:   rdata = 32'(match);
         default:      rdata = 32'd0;
      endcase
   end

   // Tick-driven counter update; a bus write to COUNT later overrides it
   always_comb begin
      count_tick = count;
      match_set  = 1'b0;
      if (tick) begin
         if (count == compare) begin
            match_set  = 1'b1;
            count_tick = ctrl[1] ? 32'd0 : count + 32'd1;
         end else begin
            count_tick = count + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'd0;
         ctrl     <= 3'd0;
         prescale <= '0;
         pre_cnt  <= '0;
         count    <= 32'd0;
         compare  <= 32'd0;
         match    <= 1'b0;
         tick     <= 1'b0;
      end else begin
         wb_ack_o <= accept;
         wb_dat_o <= accept ? rdata : 32'd0;

         // Registered tick gives first COUNT change P+2 edges after EN is written
         tick <= ctrl[0] & pre_hit;
         if ((wr_en && idx == REG_PRESCALE) || !ctrl[0] || pre_hit) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
         end

         if (wr_en && idx == REG_CTRL)     ctrl     <= ctrl_wr[2:0];
         if (wr_en && idx == REG_PRESCALE) prescale <= pre_wr[PRESCALE_W-1:0];
         if (wr_en && idx == REG_COMPARE)  compare  <= compare_wr;
         count <= (wr_en && idx == REG_COUNT) ? count_wr : count_tick;

         if (match_set) begin
            match <= 1'b1;
         end else if (wr_en && idx == REG_STATUS && wb_sel_i[0] && wb_dat_i[0]) begin
            match <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wishbone_timer.sv
// tb/tb_wishbone_timer.sv - scoreboard bench for wishbone_timer
module tb_wishbone_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [31:0] dat_r;
   logic        ack;
   logic        irq;

   wishbone_timer #(.PRESCALE_W(16)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dat_w),
      .wb_sel_i (sel),
      .wb_we_i  (we),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_dat_o (dat_r),
      .wb_ack_o (ack),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      bit          chk;
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   logic prev_ack = 1'b0;

   localparam logic [31:0] A_CTRL = 32'h00, A_PRE = 32'h04, A_CNT = 32'h08;
   localparam logic [31:0] A_CMP  = 32'h0C, A_STAT = 32'h10;

   // Monitor: every ack pops one pending expectation
   always @(negedge clk) begin
      if (ack) begin
         tests++;
         if (prev_ack) begin
            fails++;
            $display("FAIL ack_width: ack high 2+ cycles, required 1");
         end
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: ack with no pending request");
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.chk) begin
               tests++;
               if (dat_r < mon_e.lo || dat_r > mon_e.hi) begin
                  fails++;
                  $display("FAIL %s: got 0x%08h, required 0x%08h..0x%08h",
                           mon_e.nm, dat_r, mon_e.lo, mon_e.hi);
               end
            end
         end
      end
      prev_ack = ack;
   end

   task automatic acc(input bit we_v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit chk, input logic [31:0] lo,
                      input logic [31:0] hi, input string nm);
      exp_t e;
      bit   got;
      @(posedge clk);
      #1;
      adr = a; dat_w = d; sel = s; we = we_v; cyc = 1'b1; stb = 1'b1;
      e.nm = nm; e.chk = chk; e.lo = lo; e.hi = hi;
      sbq.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack) got = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: no ack within 8 cycles, required ack", nm);
         void'(sbq.pop_back());
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      acc(1'b1, a, d, s, 1'b0, 32'd0, 32'd0, "write");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi,
                     input string nm);
      acc(1'b0, a, 32'd0, 4'h0, 1'b1, lo, hi, nm);
   endtask

   task automatic rd_eq(input logic [31:0] a, input logic [31:0] v, input string nm);
      rd(a, v, v, nm);
   endtask

   task automatic chk_bit(input string nm, input logic act, input logic expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %b, required %b", nm, act, expv);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; adr = 32'd0; dat_w = 32'd0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;

      // Reset and readback of all eight offsets
      do_reset();
      chk_bit("reset_irq", irq, 1'b0);
      for (int i = 0; i < 8; i++) rd_eq(32'(i * 4), 32'd0, $sformatf("reset_rd_%0d", i));

      // Byte enables, address aliasing, unmapped offsets, read-as-zero bits
      wr(A_CMP, 32'hAABBCCDD, 4'hF);
      wr(A_CMP, 32'h11223344, 4'h5);
      rd_eq(A_CMP, 32'hAA22CC44, "sel_compare");
      rd_eq(32'h0000020C, 32'hAA22CC44, "addr_alias");
      wr(32'h18, 32'hFFFFFFFF, 4'hF);
      rd_eq(32'h18, 32'd0, "unmapped_18");
      wr(A_CTRL, 32'hFFFFFFF8, 4'hF);
      rd_eq(A_CTRL, 32'd0, "ctrl_upper_zero");
      wr(A_PRE, 32'hFFFF0000, 4'hF);
      rd_eq(A_PRE, 32'd0, "pre_upper_zero");

      // Prescaled count: PRESCALE=3 gives one increment per 4 cycles
      do_reset();
      wr(A_PRE, 32'd3, 4'hF);
      wr(A_CTRL, 32'd1, 4'hF);
      repeat (40) @(posedge clk);
      rd(A_CNT, 32'd9, 32'd11, "prescaled_count");
      wr(A_CTRL, 32'd0, 4'hF);
      rd(A_CNT, 32'd10, 32'd12, "count_after_disable");
      repeat (20) @(posedge clk);
      rd(A_CNT, 32'd10, 32'd12, "count_hold");

      // Match, AUTOCLR and IRQ; matches land 7, 13, 19 edges after the CTRL write
      do_reset();
      wr(A_PRE, 32'd0, 4'hF);
      wr(A_CMP, 32'd5, 4'hF);
      wr(A_CTRL, 32'd7, 4'hF);
      rd_eq(A_CNT, 32'd0, "match_cnt_0");
      rd_eq(A_CNT, 32'd2, "match_cnt_2");
      rd_eq(A_CNT, 32'd4, "match_cnt_4");
      rd_eq(A_STAT, 32'd1, "match_set");
      chk_bit("irq_on_match", irq, 1'b1);
      rd_eq(A_CNT, 32'd2, "autoclr_cnt_2");
      wr(A_STAT, 32'd1, 4'h1);
      chk_bit("irq_after_w1c", irq, 1'b0);
      rd_eq(A_STAT, 32'd1, "rematch");
      wr(A_STAT, 32'd1, 4'hF);
      chk_bit("irq_cleared_again", irq, 1'b0);
      @(posedge clk);
      wr(A_STAT, 32'd1, 4'h1);
      chk_bit("irq_set_wins", irq, 1'b1);
      rd_eq(A_STAT, 32'd1, "set_wins_status");

      // Wrap and COUNT-write priority over ticks
      do_reset();
      wr(A_CMP, 32'h10, 4'hF);
      wr(A_CTRL, 32'd1, 4'hF);
      wr(A_CNT, 32'hFFFFFFFE, 4'hF);
      rd_eq(A_CNT, 32'hFFFFFFFF, "wrap_ffffffff");
      rd_eq(A_CNT, 32'd1, "wrap_past_zero");
      rd_eq(A_STAT, 32'd0, "wrap_no_match");
      wr(A_CNT, 32'h100, 4'hF);
      rd_eq(A_CNT, 32'h101, "count_write_prio");
      wr(A_CNT, 32'h0000AB00, 4'h2);
      rd_eq(A_CNT, 32'h0000AB04, "count_partial_write");

      // Reset sampled on the acceptance edge
      do_reset();
      @(posedge clk);
      #1;
      adr = A_CTRL; dat_w = 32'd1; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1;
      chk_bit("rst_mid_no_ack", ack, 1'b0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_eq(A_CTRL, 32'd0, "rst_mid_ctrl");
      repeat (10) @(posedge clk);
      rd_eq(A_CNT, 32'd0, "rst_mid_count");
      chk_bit("rst_mid_irq", irq, 1'b0);

      repeat (4) @(posedge clk);
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d entries pending, required 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wishbone_timer.md
# wishbone_timer

Wishbone B4 classic slave peripheral that sits downstream of `wishbone_interconnect` on one of its slave ports, in place of a `wishbone_slave` + RAM pair. Provides a 32-bit up-counter with programmable prescaler, a compare register, a sticky match flag and a level interrupt output. Software accesses it through five word registers.

## Interface
- `PRESCALE_W`, 16: width of the prescaler register and prescaler counter.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `wb_adr_i` in 32: byte address. Only bits [4:2] are decoded; other bits are ignored.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte enables. Bit n enables byte n (bits 8n+7:8n).
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: strobe.
- `wb_dat_o` out 32: read data. Valid only while `wb_ack_o` = 1.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `irq_o` out 1: interrupt, level-sensitive.

## Operation
- Register map (offset → function). All registers reset to 0.
  - 0x00 CTRL: bit0 EN, bit1 AUTOCLR, bit2 IRQEN. Bits 31:3 read as 0.
  - 0x04 PRESCALE: bits [PRESCALE_W-1:0]. Upper bits read as 0.
  - 0x08 COUNT: 32-bit counter value.
  - 0x0C COMPARE: 32-bit compare value.
  - 0x10 STATUS: bit0 MATCH. Writing 1 to bit0 clears it (W1C); writing 0 has no effect.
- Offsets 0x14–0x1C are unmapped: reads return 0, writes are ignored, and the access is still acknowledged.
- Writes honour `wb_sel_i` per byte. A STATUS write clears MATCH only when `wb_sel_i[0]` = 1.
- Prescaler:
  - An internal counter `pre_cnt` runs while EN = 1.
  - When `pre_cnt` == PRESCALE, a one-cycle `tick` is generated and `pre_cnt` returns to 0; otherwise `pre_cnt` increments.
  - PRESCALE = 0 gives a tick every cycle.
  - While EN = 0, `pre_cnt` holds at 0 and no ticks occur.
- Counter, evaluated on a tick:
  - If COUNT == COMPARE: MATCH is set; COUNT loads 0 if AUTOCLR = 1, else COUNT increments.
  - Otherwise COUNT increments.
  - Increment wraps 0xFFFFFFFF → 0x00000000 with no flag.
- Priority and simultaneous events:
  - A bus write to COUNT overrides a tick update in the same cycle. Bytes not selected keep their pre-tick value.
  - A MATCH set and a W1C clear in the same cycle: set wins, so MATCH stays 1.
  - A PRESCALE write resets `pre_cnt` to 0.
  - Clearing EN by bus write takes effect from the next cycle. A tick in the write cycle still applies.
- `irq_o` = MATCH & IRQEN, driven from registered state with no combinational path from bus inputs.

## Timing
- Request accepted in a cycle where `wb_cyc_i` & `wb_stb_i` = 1 and `wb_ack_o` = 0.
- For an accepted request:
  - `wb_ack_o` = 1 in the following cycle, for exactly one cycle.
  - `wb_dat_o` is registered and presented in the same cycle as the ack.
- Write effect: the register updates on the clock edge that raises `wb_ack_o`. A read in the next request returns the new value.
- Read data reflects register values at the acceptance edge.
- Back-to-back requests: because an accept requires ack = 0, one access completes every 2 cycles at most.
- If the master drops `wb_cyc_i` in the ack cycle, nothing changes: the ack still pulses once and the write has already been committed.
- Reset values:
  - `wb_ack_o` = 0, `wb_dat_o` = 0, `irq_o` = 0.
  - All registers and `pre_cnt` = 0.
- Reset mid-transaction: a pending ack is dropped and the write is discarded if `rst_i` is sampled high on the same edge.
- Counter latency: with EN written at edge T and PRESCALE = P, the first tick occurs in cycle T+P+1, and COUNT changes at edge T+P+2.

## Test plan
- **Reset/readback:** assert `rst_i` for 2 cycles, then read all 8 offsets → all return 0x00000000, each ack exactly 1 cycle wide. `irq_o` = 0.
- **Byte-enable write:** write COMPARE = 0xAABBCCDD with sel 0xF, then write 0x11223344 with sel 0x5 → COMPARE reads 0xAA22CC44. Unmapped offset 0x18 write then read → 0.
- **Prescaled count:**
  - Setup: PRESCALE = 3, then CTRL = 0x1.
  - After 40 cycles, read COUNT → 10 ± 1, i.e. 1 increment per 4 cycles.
  - Clear EN → COUNT holds over the next 20 cycles.
- **Match + AUTOCLR + IRQ:**
  - Setup: PRESCALE = 0, COMPARE = 5, CTRL = 0x7.
  - COUNT sequence 0,1,2,3,4,5,0,1…
  - MATCH = 1 and `irq_o` = 1 after the 5→0 transition.
  - Write STATUS = 0x1 → MATCH = 0 and `irq_o` = 0 on the next cycle, unless a new match occurs in the same cycle, in which case MATCH stays 1.
- **Wrap and COUNT-write priority:**
  - Write COUNT = 0xFFFFFFFE with PRESCALE = 0, EN = 1, COMPARE = 0x10 → COUNT reaches 0xFFFFFFFF, then 0x00000000, and MATCH stays 0.
  - Write COUNT = 0x100 while ticking → the next read returns 0x100 plus the number of ticks elapsed since the write edge.
- **Reset mid-access:** issue a write of CTRL = 0x1 and assert `rst_i` on the acceptance edge → no ack, CTRL reads 0 after reset, and COUNT stays 0.
